// File: rtl/shift_sub_divider.sv
// Iterative restoring shift-subtract divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; start/done level handshake.
// Operands are converted to magnitudes on entry, divided unsigned, and the
// signs are reapplied in a single fix-up cycle before the result is presented.
module shift_sub_divider #(
   parameter int OPERAND_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     div_signed,
   input  logic [OPERAND_WIDTH-1:0] dividend,
   input  logic [OPERAND_WIDTH-1:0] divisor,
   output logic [OPERAND_WIDTH-1:0] quotient,
   output logic [OPERAND_WIDTH-1:0] remainder,
   output logic                     div_by_zero,
   output logic                     done
);

   localparam int N  = OPERAND_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // Counter value on the final iteration cycle.
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);
   // Most negative signed value; with divisor -1 it overflows the quotient.
   localparam logic [N-1:0]  MIN_NEG    = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state_reg, state_next;
   logic [CW-1:0]  count_reg, count_next;
   // Partial remainder; its magnitude always stays below the divisor.
   logic [N-1:0]   rem_reg,   rem_next;
   // Dividend magnitude shifting out at the top, quotient bits entering at the bottom.
   logic [N-1:0]   quo_reg,   quo_next;
   // Divisor magnitude held for the whole operation.
   logic [N-1:0]   dvs_reg,   dvs_next;
   logic           neg_q_reg, neg_q_next;
   logic           neg_r_reg, neg_r_next;
   logic           dbz_reg,   dbz_next;

   logic           dividend_neg;
   logic           divisor_neg;
   logic [N-1:0]   dividend_abs;
   logic [N-1:0]   divisor_abs;
   logic [N:0]     shifted_rem;
   logic [N:0]     trial;
   logic           in_done;

   // Operand magnitudes and the trial subtraction of the current iteration.
   always_comb begin
      dividend_neg = div_signed & dividend[N-1];
      divisor_neg  = div_signed & divisor[N-1];
      dividend_abs = dividend_neg ? (~dividend + 1'b1) : dividend;
      divisor_abs  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
      // Shift the next dividend bit into the partial remainder; N+1 bits
      // keep the carry so the trial sign is exact.
      shifted_rem  = {rem_reg, quo_reg[N-1]};
      trial        = shifted_rem - {1'b0, dvs_reg};
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         dbz_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         rem_reg   <= rem_next;
         quo_reg   <= quo_next;
         dvs_reg   <= dvs_next;
         neg_q_reg <= neg_q_next;
         neg_r_reg <= neg_r_next;
         dbz_reg   <= dbz_next;
      end
   end

   // Next-state and datapath update for each phase of the division.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      rem_next   = rem_reg;
      quo_next   = quo_reg;
      dvs_next   = dvs_reg;
      neg_q_next = neg_q_reg;
      neg_r_next = neg_r_reg;
      dbz_next   = dbz_reg;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               count_next = '0;
               dbz_next   = 1'b0;
               neg_q_next = 1'b0;
               neg_r_next = 1'b0;
               dvs_next   = divisor_abs;
               if (divisor == '0) begin
                  // Division by zero: all-ones quotient, dividend passes through.
                  quo_next   = '1;
                  rem_next   = dividend;
                  dbz_next   = 1'b1;
                  state_next = DONE;
               end else if (div_signed && (dividend == MIN_NEG) && (divisor == '1)) begin
                  // Signed overflow: quotient wraps to the dividend, no remainder.
                  quo_next   = dividend;
                  rem_next   = '0;
                  state_next = DONE;
               end else begin
                  quo_next   = dividend_abs;
                  rem_next   = '0;
                  neg_q_next = dividend_neg ^ divisor_neg;
                  neg_r_next = dividend_neg;
                  state_next = ITER;
               end
            end
         end

         ITER: begin
            // Non-negative trial means the divisor fits: keep the difference
            // and emit a 1; otherwise restore the shifted remainder and emit a 0.
            quo_next = {quo_reg[N-2:0], ~trial[N]};
            rem_next = trial[N] ? shifted_rem[N-1:0] : trial[N-1:0];
            if (count_reg == LAST_COUNT) begin
               count_next = '0;
               state_next = FIXUP;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end

         FIXUP: begin
            // Two's-complement negation maps zero to zero, so a zero result
            // never picks up a sign.
            quo_next   = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
            rem_next   = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
            state_next = DONE;
         end

         DONE: begin
            count_next = '0;
            if (!start) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_done     = (state_reg == DONE);
   assign done        = in_done;
   assign div_by_zero = dbz_reg & in_done;

   // Result buses read zero except while the result is being presented.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_out
         assign quotient[gi]  = quo_reg[gi] & in_done;
         assign remainder[gi] = rem_reg[gi] & in_done;
      end
   endgenerate

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed RV32M corner cases,
// reset abort, and randomized signed/unsigned divisions against a
// plain-arithmetic reference model.
module tb_shift_sub_divider;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          div_signed = 1'b0;
   logic [N-1:0]  dividend = '0;
   logic [N-1:0]  divisor = '0;
   logic [N-1:0]  quotient;
   logic [N-1:0]  remainder;
   logic          div_by_zero;
   logic          done;

   int            checks = 0;
   int            failures = 0;

   // Expectation published by the driver for the compare process.
   logic [N-1:0]  exp_q = '0;
   logic [N-1:0]  exp_r = '0;
   logic          exp_dbz = 1'b0;
   logic          exp_valid = 1'b0;
   bit            armed = 1'b0;

   shift_sub_divider #(.OPERAND_WIDTH(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .div_signed  (div_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Reference: RISC-V division semantics using 64-bit integer arithmetic.
   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic dbz, output int lat);
      longint sa, sb, lo;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lo  = -(longint'(1) <<< 31);
      dbz = 1'b0;
      lat = N + 2;
      if (b == '0) begin
         q = '1; r = a; dbz = 1'b1; lat = 1;
      end else if (sgn) begin
         if (sa == lo && sb == -1) begin
            q = a; r = '0; lat = 1;
         end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Every cycle after reset: results only while done, zeros otherwise.
   always @(negedge clk) begin
      if (armed && !rst) begin
         if (done) begin
            chk("done_allowed", 32'(done), 32'(exp_valid));
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
         end else begin
            chk("idle_quotient", quotient, '0);
            chk("idle_remainder", remainder, '0);
            chk("idle_dbz", 32'(div_by_zero), '0);
         end
      end
   end

   // One operation: start at a negedge, wait for done, hold, then drop start.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn,
                         input int hold, input bit drop_early);
      logic [N-1:0] eq, er, got_q, got_r;
      logic         ed;
      int           lat, cycles;
      bit           got, early;
      model(a, b, sgn, eq, er, ed, lat);
      early      = drop_early && (lat > 3);
      exp_q      = eq;
      exp_r      = er;
      exp_dbz    = ed;
      exp_valid  = 1'b1;
      dividend   = a;
      divisor    = b;
      div_signed = sgn;
      start      = 1'b1;
      cycles     = 0;
      got        = 1'b0;
      got_q      = '0;
      got_r      = '0;
      while (!got && cycles < 100) begin
         @(negedge clk);
         cycles++;
         // Operands after sampling must be ignored.
         dividend = $urandom;
         divisor  = $urandom;
         if (early && cycles == 3) start = 1'b0;
         if (done) begin
            got   = 1'b1;
            got_q = quotient;
            got_r = remainder;
         end
      end
      chk("latency", 32'(cycles), 32'(lat));
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_held", 32'(done), 32'd1);
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_drop", 32'(done), 32'd0);
      exp_valid = 1'b0;
      $display("op sgn=%0d a=0x%08h b=0x%08h q=0x%08h r=0x%08h dbz=%0d lat=%0d", sgn, a, b,
               got_q, got_r, ed, cycles);
   endtask

   initial begin
      logic [N-1:0] mq, mr, a, b;
      logic         md;
      int           ml;
      bit           sgn;

      // Pin the reference model with hand-computed values.
      model(32'd100, 32'd7, 1'b0, mq, mr, md, ml);
      chk("model_divu_q", mq, 32'd14);
      chk("model_divu_r", mr, 32'd2);
      chk("model_divu_lat", 32'(ml), 32'd34);
      model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, md, ml);
      chk("model_neg7_q", mq, 32'hFFFF_FFFD);
      chk("model_neg7_r", mr, 32'hFFFF_FFFF);
      model(32'd7, 32'hFFFF_FFFE, 1'b1, mq, mr, md, ml);
      chk("model_7neg2_q", mq, 32'hFFFF_FFFD);
      chk("model_7neg2_r", mr, 32'd1);
      model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, md, ml);
      chk("model_ovf_q", mq, 32'h8000_0000);
      chk("model_ovf_lat", 32'(ml), 32'd1);
      model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mq, mr, md, ml);
      chk("model_u_q", mq, 32'd0);
      chk("model_u_r", mr, 32'h8000_0000);
      model(32'd5, 32'd0, 1'b1, mq, mr, md, ml);
      chk("model_dbz_flag", 32'(md), 32'd1);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", quotient, '0);
      chk("rst_r", remainder, '0);
      chk("rst_dbz", 32'(div_by_zero), '0);
      rst   = 1'b0;
      armed = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_op(32'd100, 32'd7, 1'b0, 2, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
      run_op(32'd5, 32'd0, 1'b1, 1, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFC, 32'd4, 1'b1, 0, 1'b1);
      run_op(32'd0, 32'hFFFF_FFFD, 1'b1, 0, 1'b0);

      // Reset during ITER cycle 10 aborts without ever asserting done.
      exp_valid  = 1'b0;
      dividend   = 32'd1000;
      divisor    = 32'd7;
      div_signed = 1'b0;
      start      = 1'b1;
      repeat (10) @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i % 8 == 0) chk("abort_no_done", 32'(done), 32'd0);
      end
      run_op(32'd9, 32'd3, 1'b0, 0, 1'b0);

      // Randomized operations, biased toward the interesting corners.
      for (int k = 0; k < 150; k++) begin
         sgn = 1'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = 32'($urandom_range(1, 300));
            default: b = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 1000));
            default: a = $urandom;
         endcase
         run_op(a, b, sgn, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
